// File: rtl/reg_operand_bypass_pkg.sv
// Shared constants and types for the ID-stage operand resolver.
// Widths of the zero constants are fixed at the use site with a cast.
package reg_operand_bypass_pkg;

  localparam logic        READ_ENABLE   = 1'b1;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam int unsigned ZERO_WORD     = 0;
  localparam int unsigned ZERO_REG_ADDR = 0;

  typedef enum logic [1:0] {
    SrcZero,
    SrcRf,
    SrcFwd,
    SrcWait
  } op_src_e;

  // Select width for an n-way index, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_operand_bypass_mux.sv
// Single read-port resolver: r0/disable, youngest-first bypass match, register file fallback.
// Flags the port unresolved when the youngest matching stage has no data yet.
module operand_bypass_mux
  import reg_operand_bypass_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic [DATA_W-1:0]           rf_data,
  input  logic [NUM_FWD-1:0]          fwd_wen,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]          fwd_rdy,
  output logic [DATA_W-1:0]           value,
  output logic                        unresolved
);

  localparam int unsigned IdxW = idx_width(NUM_FWD);

  op_src_e         src;
  logic [IdxW-1:0] sel;

  // Scan oldest to youngest so the youngest match overwrites, ready or not.
  always_comb begin
    src = SrcRf;
    sel = '0;
    for (int s = NUM_FWD - 1; s >= 0; s--) begin
      if (fwd_wen[s] == WRITE_ENABLE && fwd_addr[s*ADDR_W +: ADDR_W] == rd_addr) begin
        src = fwd_rdy[s] ? SrcFwd : SrcWait;
        sel = IdxW'(s);
      end
    end
    if (rd_en != READ_ENABLE || rd_addr == ADDR_W'(ZERO_REG_ADDR)) begin
      src = SrcZero;
    end
  end

  always_comb begin
    value      = DATA_W'(ZERO_WORD);
    unresolved = 1'b0;
    unique case (src)
      SrcRf:   value = rf_data;
      SrcFwd:  value = fwd_data[sel*DATA_W +: DATA_W];
      SrcWait: unresolved = 1'b1;
      default: value = DATA_W'(ZERO_WORD);
    endcase
  end

endmodule

// File: rtl/reg_operand_bypass.sv
// ID-stage operand resolver with load-use stall, ID->EX operand latch and a stall counter.
// One operand_bypass_mux per read port; this level owns the handshake and state.
module reg_operand_bypass
  import reg_operand_bypass_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]    rf_data,
  input  logic [NUM_FWD-1:0]          fwd_wen,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]          fwd_rdy,
  input  logic                        id_valid,
  output logic                        id_ready,
  input  logic                        ex_ready,
  input  logic                        flush,
  input  logic                        stat_clr,
  output logic                        op_valid,
  output logic [NUM_RD*DATA_W-1:0]    op_data,
  output logic                        hazard,
  output logic [CNT_W-1:0]            stall_cycles
);

  logic [NUM_RD*DATA_W-1:0] resolved;
  logic [NUM_RD-1:0]        unresolved;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    operand_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .rd_en      (rd_en[p]),
      .rd_addr    (rd_addr[p*ADDR_W +: ADDR_W]),
      .rf_data    (rf_data[p*DATA_W +: DATA_W]),
      .fwd_wen    (fwd_wen),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data),
      .fwd_rdy    (fwd_rdy),
      .value      (resolved[p*DATA_W +: DATA_W]),
      .unresolved (unresolved[p])
    );
  end

  // Release is purely combinational so id_ready rises with fwd_rdy.
  always_comb begin
    hazard   = id_valid & (|unresolved);
    id_ready = ~flush & ~hazard & (~op_valid | ex_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_data  <= '0;
    end else if (flush) begin
      op_valid <= 1'b0;
      op_data  <= '0;
    end else if (id_valid && id_ready) begin
      op_valid <= 1'b1;
      op_data  <= resolved;
    end else if (ex_ready) begin
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (hazard && !flush && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_operand_bypass.sv
// Directed bench for reg_operand_bypass: forwarding priority, load-use stall,
// r0/disable, backpressure, flush, counter saturation and async reset.
module tb_reg_operand_bypass;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned NUM_FWD = 3;
  localparam int unsigned CNT_W   = 16;

  logic                       clk;
  logic                       rst;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rf_data;
  logic [NUM_FWD-1:0]         fwd_wen;
  logic [NUM_FWD*ADDR_W-1:0]  fwd_addr;
  logic [NUM_FWD*DATA_W-1:0]  fwd_data;
  logic [NUM_FWD-1:0]         fwd_rdy;
  logic                       id_valid;
  logic                       id_ready;
  logic                       ex_ready;
  logic                       flush;
  logic                       stat_clr;
  logic                       op_valid;
  logic [NUM_RD*DATA_W-1:0]   op_data;
  logic                       hazard;
  logic [CNT_W-1:0]           stall_cycles;

  int n_tests;
  int n_fail;

  reg_operand_bypass #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_FWD (NUM_FWD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rf_data      (rf_data),
    .fwd_wen      (fwd_wen),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_rdy      (fwd_rdy),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .stat_clr     (stat_clr),
    .op_valid     (op_valid),
    .op_data      (op_data),
    .hazard       (hazard),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int s, input logic wen, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic rdy);
    fwd_wen[s]                    = wen;
    fwd_addr[s*ADDR_W +: ADDR_W]  = addr;
    fwd_data[s*DATA_W +: DATA_W]  = data;
    fwd_rdy[s]                    = rdy;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rd_en    = '0;
    rd_addr  = '0;
    rf_data  = '0;
    fwd_wen  = '0;
    fwd_addr = '0;
    fwd_data = '0;
    fwd_rdy  = '0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    flush    = 1'b0;
    stat_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_data0", op_data[31:0], 32'd0);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    tick();
    rst = 1'b0;

    // 1: no match, register file value
    rd_en                = 2'b01;
    rd_addr[4:0]         = 5'd3;
    rf_data[31:0]        = 32'h11;
    rd_addr[9:5]         = 5'd4;
    rf_data[63:32]       = 32'hDEAD;
    id_valid             = 1'b1;
    #1;
    chk("t1_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("t1_op_valid", {31'd0, op_valid}, 32'd1);
    chk("t1_op_data0", op_data[31:0], 32'h11);
    chk("t1_op_data1_disabled", op_data[63:32], 32'd0);

    // 2: EX beats MEM when both ready
    rd_addr[4:0] = 5'd5;
    set_fwd(0, 1'b1, 5'd5, 32'hAA, 1'b1);
    set_fwd(1, 1'b1, 5'd5, 32'hBB, 1'b1);
    #1;
    chk("t2_id_ready_pipe", {31'd0, id_ready}, 32'd1);
    tick();
    chk("t2_prio_data", op_data[31:0], 32'hAA);
    // EX unready blocks the ready MEM match
    fwd_rdy[0] = 1'b0;
    #1;
    chk("t2_hazard", {31'd0, hazard}, 32'd1);
    chk("t2_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("t2_bubble", {31'd0, op_valid}, 32'd0);
    chk("t2_bubble_data_held", op_data[31:0], 32'hAA);
    chk("t2_stall", {16'd0, stall_cycles}, 32'd1);
    id_valid = 1'b0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t2_stat_clr", {16'd0, stall_cycles}, 32'd0);

    // 3: load-use on r7, WB has an older ready copy
    rd_addr[4:0] = 5'd7;
    set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
    set_fwd(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fwd(2, 1'b1, 5'd7, 32'h55, 1'b1);
    id_valid = 1'b1;
    #1;
    chk("t3_hazard", {31'd0, hazard}, 32'd1);
    tick();
    chk("t3_bubble", {31'd0, op_valid}, 32'd0);
    chk("t3_stall", {16'd0, stall_cycles}, 32'd1);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_fwd(1, 1'b1, 5'd7, 32'h99, 1'b1);
    #1;
    chk("t3_release_hazard", {31'd0, hazard}, 32'd0);
    chk("t3_release_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("t3_op_valid", {31'd0, op_valid}, 32'd1);
    chk("t3_mem_data", op_data[31:0], 32'h99);
    chk("t3_stall_hold", {16'd0, stall_cycles}, 32'd1);

    // 4: r0 never forwarded, disabled port ignores an unready match
    rd_en          = 2'b01;
    rd_addr[4:0]   = 5'd0;
    rf_data[31:0]  = 32'h1234;
    rd_addr[9:5]   = 5'd5;
    rf_data[63:32] = 32'h5678;
    set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b0);
    set_fwd(1, 1'b1, 5'd5, 32'hBB, 1'b0);
    set_fwd(2, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("t4_hazard", {31'd0, hazard}, 32'd0);
    tick();
    chk("t4_r0", op_data[31:0], 32'd0);
    chk("t4_disabled", op_data[63:32], 32'd0);
    fwd_wen = '0;

    // 5: backpressure holds operands, then flush drops them
    rd_en         = 2'b01;
    rd_addr[4:0]  = 5'd3;
    rf_data[31:0] = 32'h22;
    tick();
    chk("t5_capture", op_data[31:0], 32'h22);
    ex_ready      = 1'b0;
    rf_data[31:0] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_id_ready_bp", {31'd0, id_ready}, 32'd0);
      tick();
      chk("t5_hold_valid", {31'd0, op_valid}, 32'd1);
      chk("t5_hold_data", op_data[31:0], 32'h22);
    end
    flush = 1'b1;
    #1;
    chk("t5_flush_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", {31'd0, op_valid}, 32'd0);
    chk("t5_flush_data", op_data[31:0], 32'd0);

    // 6: capture under backpressure, then stall long enough to saturate
    rf_data[31:0] = 32'h77;
    tick();
    chk("t6_capture", op_data[31:0], 32'h77);
    rd_addr[4:0] = 5'd7;
    set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t6_clr_start", {16'd0, stall_cycles}, 32'd0);
    for (int i = 0; i < 65534; i++) tick();
    chk("t6_near_sat", {16'd0, stall_cycles}, 32'hFFFE);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_saturated", {16'd0, stall_cycles}, 32'hFFFF);
    chk("t6_held_valid", {31'd0, op_valid}, 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t6_clr_wins", {16'd0, stall_cycles}, 32'd0);
    tick();
    tick();
    chk("t6_recount", {16'd0, stall_cycles}, 32'd2);
    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("t6_rst_valid", {31'd0, op_valid}, 32'd0);
    chk("t6_rst_data", op_data[31:0], 32'd0);
    chk("t6_rst_hazard_comb", {31'd0, hazard}, 32'd1);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
